// File: rtl/fetch_predict_pkg.sv
// fetch_predict_pkg: shared types for the fetch/predict stage.
//   pht_ctr_t      2-bit saturating branch counter
//   PHT_INIT       counter value after reset (weakly not-taken)
//   OP_BR          RV32I conditional-branch opcode
//   fetch_state_t  fetch FSM states
//   b_imm()        sign-extended B-type immediate
//   ctr_step()     saturating counter update
package fetch_predict_pkg;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t   PHT_INIT = 2'b01;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // 00 and 11 saturate.
    function automatic pht_ctr_t ctr_step(input pht_ctr_t ctr, input logic taken);
        pht_ctr_t res;
        res = ctr;
        if (taken && ctr != 2'b11)
            res = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            res = ctr - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/fetch_predict_pht.sv
// fetch_predict_pht (pht_2bit): array of 2**BITS two-bit saturating counters.
//   clk, rst     clock, asynchronous active-high reset (all counters -> PHT_INIT)
//   rd_idx       combinational read index
//   rd_pred      predicted taken (MSB of the addressed counter, pre-update value)
//   upd_en       update strobe
//   upd_idx      counter to update
//   upd_taken    actual outcome: +1 if taken, -1 if not, saturating
module pht_2bit
    import fetch_predict_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] rd_idx,
    output logic            rd_pred,
    input  logic            upd_en,
    input  logic [BITS-1:0] upd_idx,
    input  logic            upd_taken
);

    pht_ctr_t ctr [2**BITS];

    // Read is purely combinational from the array, so a same-cycle update
    // to the same entry is only visible from the next cycle.
    assign rd_pred = ctr[rd_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**BITS; i++)
                ctr[i] <= PHT_INIT;
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_step(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/fetch_predict.sv
// fetch_predict: IF stage. Owns the PC, runs the instruction-memory read
// handshake, predecodes conditional branches and predicts them with a 2-bit PHT.
// Optional macro GSHARE_PREDICT_EN: XOR a global history register into the PHT index.
//
// Handshake: imem_read is held high while a request is outstanding; imem_resp is a
// one-cycle pulse carrying imem_rdata. A word is delivered to IF/ID only on the
// cycle ifid_load is high; ifid_load is never high while stall is high.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_read/imem_address   fetch request and word address (= pc)
//   imem_resp/imem_rdata     response pulse and instruction word
//   stall                    downstream cannot accept
//   ifid_load                IF/ID load strobe
//   pc_plus4_out .. pht_prediction_out   delivered instruction and its prediction
//   br_update/br_update_idx/br_taken     PHT training from EX
//   redirect/redirect_pc     misprediction refetch from EX
//   fsm_state                current FSM state (observability)
module fetch_predict
    import fetch_predict_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          PHT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_read,
    output logic [31:0]         imem_address,
    input  logic                imem_resp,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    output logic                ifid_load,
    output logic [31:0]         pc_plus4_out,
    output logic [31:0]         instr_out,
    output logic                is_branch_out,
    output logic [PHT_BITS-1:0] pht_idx_out,
    output logic [31:0]         pc_taken_out,
    output logic                pht_prediction_out,
    input  logic                br_update,
    input  logic [PHT_BITS-1:0] br_update_idx,
    input  logic                br_taken,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output fetch_state_t        fsm_state
);

    fetch_state_t        state, state_next;
    logic [31:0]         pc, pc_next;
    logic [31:0]         held;
    logic                capture;
    logic [31:0]         word;
    logic                word_valid;
    logic                is_branch;
    logic [31:0]         pc_plus4, pc_taken, next_seq;
    logic [PHT_BITS-1:0] rd_idx;
    logic                pred;

`ifdef GSHARE_PREDICT_EN
    logic [PHT_BITS-1:0] ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr <= '0;
        else if (br_update)
            ghr <= {ghr[PHT_BITS-2:0], br_taken};
    end

    assign rd_idx = pc[PHT_BITS+1:2] ^ ghr;
`else
    assign rd_idx = pc[PHT_BITS+1:2];
`endif

    pht_2bit #(.BITS(PHT_BITS)) u_pht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_pred   (pred),
        .upd_en    (br_update),
        .upd_idx   (br_update_idx),
        .upd_taken (br_taken)
    );

    // In HOLD the word comes from the capture register, otherwise straight
    // from memory; outputs are zero whenever no word is on offer.
    assign word       = (state == HOLD) ? held : imem_rdata;
    assign word_valid = (state == HOLD) || (state == FETCH && imem_resp);
    assign is_branch  = (word[6:0] == OP_BR);
    assign pc_plus4   = pc + 32'd4;
    assign pc_taken   = pc + b_imm(word);
    assign next_seq   = (is_branch && pred) ? pc_taken : pc_plus4;

    assign pc_plus4_out       = word_valid ? pc_plus4  : '0;
    assign instr_out          = word_valid ? word      : '0;
    assign is_branch_out      = word_valid && is_branch;
    assign pht_idx_out        = word_valid ? rd_idx    : '0;
    assign pc_taken_out       = word_valid ? pc_taken  : '0;
    assign pht_prediction_out = word_valid && pred;

    assign imem_address = pc;
    // No request while in reset; HOLD already owns its word.
    assign imem_read    = !rst && (state != HOLD);
    assign fsm_state    = state;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ifid_load  = 1'b0;
        capture    = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                    // Request still in flight: its response must be dropped.
                    if (!imem_resp)
                        state_next = DRAIN;
                end else if (imem_resp) begin
                    if (stall) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_next   = next_seq;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    pc_next    = next_seq;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (redirect)
                    pc_next = redirect_pc;
                if (imem_resp)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            held  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture)
                held <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
module tb_fetch_predict;
    import fetch_predict_pkg::*;

    logic         clk;
    logic         rst;
    logic         imem_read;
    logic [31:0]  imem_address;
    logic         imem_resp;
    logic [31:0]  imem_rdata;
    logic         stall;
    logic         ifid_load;
    logic [31:0]  pc_plus4_out;
    logic [31:0]  instr_out;
    logic         is_branch_out;
    logic [3:0]   pht_idx_out;
    logic [31:0]  pc_taken_out;
    logic         pht_prediction_out;
    logic         br_update;
    logic [3:0]   br_update_idx;
    logic         br_taken;
    logic         redirect;
    logic [31:0]  redirect_pc;
    fetch_state_t fsm_state;

    int checks = 0;
    int errors = 0;

    fetch_predict dut (
        .clk                (clk),
        .rst                (rst),
        .imem_read          (imem_read),
        .imem_address       (imem_address),
        .imem_resp          (imem_resp),
        .imem_rdata         (imem_rdata),
        .stall              (stall),
        .ifid_load          (ifid_load),
        .pc_plus4_out       (pc_plus4_out),
        .instr_out          (instr_out),
        .is_branch_out      (is_branch_out),
        .pht_idx_out        (pht_idx_out),
        .pc_taken_out       (pc_taken_out),
        .pht_prediction_out (pht_prediction_out),
        .br_update          (br_update),
        .br_update_idx      (br_update_idx),
        .br_taken           (br_taken),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .fsm_state          (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply one cycle of inputs at the falling edge, settle 1 time unit.
    task automatic drive(input logic resp, input logic [31:0] rdata, input logic stl,
                         input logic rd, input logic [31:0] rpc,
                         input logic upd, input logic [3:0] uidx, input logic ut);
        @(negedge clk);
        imem_resp     = resp;
        imem_rdata    = rdata;
        stall         = stl;
        redirect      = rd;
        redirect_pc   = rpc;
        br_update     = upd;
        br_update_idx = uidx;
        br_taken      = ut;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_resp = 1'b0; imem_rdata = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        br_update = 1'b0; br_update_idx = '0; br_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_imem_read: got %0b exp 0", imem_read); end
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL reset_ifid_load: got %0b exp 0", ifid_load); end
        checks++; if (imem_address !== 32'h60) begin errors++; $display("FAIL reset_address: got %h exp 00000060", imem_address); end
        checks++; if ({pc_plus4_out, instr_out, pc_taken_out} !== 96'h0) begin errors++; $display("FAIL reset_outs: got %h %h %h exp 0", pc_plus4_out, instr_out, pc_taken_out); end
        checks++; if ({is_branch_out, pht_idx_out, pht_prediction_out} !== 6'h0) begin errors++; $display("FAIL reset_flags: got %b %h %b exp 0", is_branch_out, pht_idx_out, pht_prediction_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL post_reset_read: got %0b exp 1", imem_read); end
        checks++; if (fsm_state !== FETCH) begin errors++; $display("FAIL post_reset_state: got %0d exp %0d", fsm_state, FETCH); end
    endtask

    task automatic test_sequential();
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (ifid_load !== 1'b1) begin errors++; $display("FAIL seq_load: got %0b exp 1", ifid_load); end
        checks++; if (pc_plus4_out !== 32'h64) begin errors++; $display("FAIL seq_pc_plus4: got %h exp 00000064", pc_plus4_out); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL seq_instr: got %h exp 00000013", instr_out); end
        checks++; if (is_branch_out !== 1'b0) begin errors++; $display("FAIL seq_is_branch: got %0b exp 0", is_branch_out); end
        idle();
        checks++; if (imem_address !== 32'h64) begin errors++; $display("FAIL seq_next_addr: got %h exp 00000064", imem_address); end
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL seq_idle_load: got %0b exp 0", ifid_load); end
    endtask

    task automatic test_branch_nt();
        drive(1'b1, 32'h0000_0463, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (is_branch_out !== 1'b1) begin errors++; $display("FAIL bnt_is_branch: got %0b exp 1", is_branch_out); end
        checks++; if (pht_prediction_out !== 1'b0) begin errors++; $display("FAIL bnt_pred: got %0b exp 0", pht_prediction_out); end
        checks++; if (pc_taken_out !== 32'h6C) begin errors++; $display("FAIL bnt_pc_taken: got %h exp 0000006c", pc_taken_out); end
        checks++; if (pht_idx_out !== 4'h9) begin errors++; $display("FAIL bnt_idx: got %h exp 9", pht_idx_out); end
        checks++; if (ifid_load !== 1'b1) begin errors++; $display("FAIL bnt_load: got %0b exp 1", ifid_load); end
        idle();
        checks++; if (imem_address !== 32'h68) begin errors++; $display("FAIL bnt_next_addr: got %h exp 00000068", imem_address); end
    endtask

    task automatic test_pht_train();
        // Two taken updates at idx 9: 01 -> 10 -> 11. Redirect back to 0x64.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h9, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h64, 1'b1, 4'h9, 1'b1);
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL train_redirect_load: got %0b exp 0", ifid_load); end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (fsm_state !== DRAIN) begin errors++; $display("FAIL train_drain_state: got %0d exp %0d", fsm_state, DRAIN); end
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL train_drain_load: got %0b exp 0", ifid_load); end
        checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL train_drain_read: got %0b exp 1", imem_read); end
        drive(1'b1, 32'h0000_0463, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (imem_address !== 32'h64) begin errors++; $display("FAIL train_refetch_addr: got %h exp 00000064", imem_address); end
        checks++; if (pht_prediction_out !== 1'b1) begin errors++; $display("FAIL train_pred_taken: got %0b exp 1", pht_prediction_out); end
        checks++; if (ifid_load !== 1'b1) begin errors++; $display("FAIL train_load: got %0b exp 1", ifid_load); end
        idle();
        checks++; if (imem_address !== 32'h6C) begin errors++; $display("FAIL train_next_taken: got %h exp 0000006c", imem_address); end
        // Third taken must saturate at 11; then one not-taken -> 10 (still taken).
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h9, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h64, 1'b1, 4'h9, 1'b0);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        // Same-cycle not-taken update to idx 9: read must see pre-update 10.
        drive(1'b1, 32'h0000_0463, 1'b0, 1'b0, 32'h0, 1'b1, 4'h9, 1'b0);
        checks++; if (pht_prediction_out !== 1'b1) begin errors++; $display("FAIL train_saturate_bypass: got %0b exp 1", pht_prediction_out); end
        idle();
        checks++; if (imem_address !== 32'h6C) begin errors++; $display("FAIL train_next_taken2: got %h exp 0000006c", imem_address); end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL stall_resp_load: got %0b exp 0", ifid_load); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
            checks++; if (fsm_state !== HOLD) begin errors++; $display("FAIL stall_state_%0d: got %0d exp %0d", i, fsm_state, HOLD); end
            checks++; if ({imem_read, ifid_load} !== 2'b00) begin errors++; $display("FAIL stall_ctrl_%0d: got %b exp 00", i, {imem_read, ifid_load}); end
            checks++; if (instr_out !== 32'h13 || pc_plus4_out !== 32'h70) begin errors++; $display("FAIL stall_hold_%0d: got %h %h exp 00000013 00000070", i, instr_out, pc_plus4_out); end
        end
        idle();
        checks++; if (ifid_load !== 1'b1) begin errors++; $display("FAIL stall_release_load: got %0b exp 1", ifid_load); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL stall_release_instr: got %h exp 00000013", instr_out); end
        idle();
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL stall_single_load: got %0b exp 0", ifid_load); end
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h70) begin errors++; $display("FAIL stall_next_fetch: got %0b %h exp 1 00000070", imem_read, imem_address); end
    endtask

    task automatic test_redirect_pending();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 4'h0, 1'b0);
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL rdp_load: got %0b exp 0", ifid_load); end
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (fsm_state !== DRAIN) begin errors++; $display("FAIL rdp_state: got %0d exp %0d", fsm_state, DRAIN); end
        checks++; if (imem_address !== 32'h200) begin errors++; $display("FAIL rdp_addr: got %h exp 00000200", imem_address); end
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL rdp_discard: got %0b exp 0", ifid_load); end
        idle();
        checks++; if (fsm_state !== FETCH || imem_address !== 32'h200) begin errors++; $display("FAIL rdp_refetch: got %0d %h exp %0d 00000200", fsm_state, imem_address, FETCH); end
    endtask

    task automatic test_redirect_coincident();
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h300, 1'b0, 4'h0, 1'b0);
        checks++; if (ifid_load !== 1'b0) begin errors++; $display("FAIL rdc_load: got %0b exp 0", ifid_load); end
        idle();
        checks++; if (fsm_state !== FETCH) begin errors++; $display("FAIL rdc_state: got %0d exp %0d", fsm_state, FETCH); end
        checks++; if (imem_address !== 32'h300) begin errors++; $display("FAIL rdc_addr: got %h exp 00000300", imem_address); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (ifid_load !== 1'b1 || pc_plus4_out !== 32'h304) begin errors++; $display("FAIL b2b_first: got %0b %h exp 1 00000304", ifid_load, pc_plus4_out); end
        // Backward branch, imm = -8, at 0x304 (idx 1, counter 01).
        drive(1'b1, 32'hFE00_0CE3, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (ifid_load !== 1'b1 || pc_plus4_out !== 32'h308) begin errors++; $display("FAIL b2b_second: got %0b %h exp 1 00000308", ifid_load, pc_plus4_out); end
        checks++; if (pc_taken_out !== 32'h2FC) begin errors++; $display("FAIL b2b_neg_target: got %h exp 000002fc", pc_taken_out); end
        checks++; if (pht_idx_out !== 4'h1 || pht_prediction_out !== 1'b0) begin errors++; $display("FAIL b2b_pred: got %h %0b exp 1 0", pht_idx_out, pht_prediction_out); end
        idle();
        checks++; if (imem_address !== 32'h308) begin errors++; $display("FAIL b2b_next_addr: got %h exp 00000308", imem_address); end
    endtask

`ifdef GSHARE_PREDICT_EN
    task automatic test_gshare();
        // Outcomes T,N,T -> GHR 0101; fetch 0x64 -> index 9 ^ 5 = C.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h64, 1'b1, 4'h0, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        drive(1'b1, 32'h0000_0463, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        checks++; if (pht_idx_out !== 4'hC) begin errors++; $display("FAIL gshare_idx: got %h exp c", pht_idx_out); end
        checks++; if (pht_prediction_out !== 1'b0 || ifid_load !== 1'b1) begin errors++; $display("FAIL gshare_pred: got %0b %0b exp 0 1", pht_prediction_out, ifid_load); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch_nt();
`ifdef GSHARE_PREDICT_EN
        test_gshare();
`else
        test_pht_train();
        test_stall();
        test_redirect_pending();
        test_redirect_coincident();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
